// File: rtl/wb_regfile_writer_pkg.sv
// Shared constants, types and the result-select helper for the MEM/WB writer slice.
package wb_regfile_writer_pkg;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int RW    = $clog2(NREG);
  localparam int CNT_W = 2;

  localparam logic [1:0] RESSRC_ALU = 2'b00;
  localparam logic [1:0] RESSRC_LD  = 2'b01;
  localparam logic [1:0] RESSRC_PC4 = 2'b10;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_WAIT_LD = 2'b01;
  localparam logic [1:0] ST_WRITE   = 2'b10;

  // Only rd/regwrite must survive a load wait; the data goes straight to WD3.
  typedef struct packed {
    logic          regwrite;
    logic [RW-1:0] rd;
  } wb_pend_t;

  // Reserved encoding 2'b11 falls back to the ALU result.
  function automatic logic [XLEN-1:0] sel_result(input logic [1:0]      ressrc,
                                                 input logic [XLEN-1:0] alu,
                                                 input logic [XLEN-1:0] ld,
                                                 input logic [XLEN-1:0] pc4);
    case (ressrc)
      RESSRC_LD:  sel_result = ld;
      RESSRC_PC4: sel_result = pc4;
      default:    sel_result = alu;
    endcase
  endfunction

endpackage

// File: rtl/wb_regfile_writer_scoreboard.sv
// Per-register in-flight write counters; hazard_o is combinational on rs1/rs2.
// Latency: counters update on the edge after issue/write; no backpressure, overflow is flagged sticky.
module wb_scoreboard
  import wb_regfile_writer_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          iss_valid_i,
  input  logic          iss_regwrite_i,
  input  logic [RW-1:0] iss_rd_i,
  input  logic          wr_en_i,
  input  logic [RW-1:0] wr_rd_i,
  input  logic [RW-1:0] rs1_i,
  input  logic [RW-1:0] rs2_i,
  output logic          hazard_o,
  output logic          sb_ovf_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  inc_v;
  logic [NREG-1:0]  dec_v;
  logic             dec1;
  logic             dec2;

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int r = 1; r < NREG; r++) begin
      inc_v[r] = iss_valid_i & iss_regwrite_i & (iss_rd_i == RW'(r));
      dec_v[r] = wr_en_i & (wr_rd_i == RW'(r));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      sb_ovf_o <= 1'b0;
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < NREG; r++) begin
        if (inc_v[r] && !dec_v[r]) begin
          if (cnt[r] == CNT_MAX) sb_ovf_o <= 1'b1;
          else                   cnt[r]   <= cnt[r] + 1'b1;
        end else if (dec_v[r] && !inc_v[r] && cnt[r] != '0) begin
          cnt[r] <= cnt[r] - 1'b1;
        end
      end
    end
  end

  // A write this cycle retires one pending entry: the register file is write-before-read.
  always_comb begin
    dec1     = wr_en_i & (wr_rd_i == rs1_i);
    dec2     = wr_en_i & (wr_rd_i == rs2_i);
    hazard_o = ((rs1_i != '0) && (cnt[rs1_i] > CNT_W'(dec1))) ||
               ((rs2_i != '0) && (cnt[rs2_i] > CNT_W'(dec2)));
  end

endmodule

// File: rtl/wb_regfile_writer.sv
// MEM/WB stage: selects the retiring result, waits for late load data, drives WE3/A3/WD3.
// Latency: one cycle from transfer to write; wb_ready_o drops only while waiting for load data.
module wb_regfile_writer
  import wb_regfile_writer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid_i,
  output logic            wb_ready_o,
  input  logic            mem_regwrite_i,
  input  logic [RW-1:0]   mem_rd_i,
  input  logic [1:0]      mem_ressrc_i,
  input  logic [XLEN-1:0] mem_alu_i,
  input  logic [XLEN-1:0] mem_pc4_i,
  input  logic            ld_valid_i,
  input  logic [XLEN-1:0] ld_data_i,
  input  logic            iss_valid_i,
  input  logic            iss_regwrite_i,
  input  logic [RW-1:0]   iss_rd_i,
  input  logic [RW-1:0]   rs1_i,
  input  logic [RW-1:0]   rs2_i,
  output logic            hazard_o,
  output logic            rf_we_o,
  output logic [RW-1:0]   rf_a3_o,
  output logic [XLEN-1:0] rf_wd3_o,
  output logic            sb_ovf_o
);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  wb_pend_t        pend;
  logic            xfer;
  logic            commit_new;
  logic            commit_ld;
  logic            wr_en;
  logic [RW-1:0]   wr_rd;
  logic [XLEN-1:0] wr_dat;

  always_comb begin
    wb_ready_o = (state != ST_WAIT_LD);
    xfer       = mem_valid_i & wb_ready_o;
    commit_new = xfer & ((mem_ressrc_i != RESSRC_LD) | ld_valid_i);
    commit_ld  = (state == ST_WAIT_LD) & ld_valid_i;

    if (commit_ld) begin
      wr_en  = pend.regwrite;
      wr_rd  = pend.rd;
      wr_dat = ld_data_i;
    end else begin
      wr_en  = mem_regwrite_i;
      wr_rd  = mem_rd_i;
      wr_dat = sel_result(mem_ressrc_i, mem_alu_i, ld_data_i, mem_pc4_i);
    end

    if (xfer)                      state_nxt = commit_new ? ST_WRITE : ST_WAIT_LD;
    else if (state == ST_WAIT_LD)  state_nxt = ld_valid_i ? ST_WRITE : ST_WAIT_LD;
    else                           state_nxt = ST_IDLE;
  end

  // A3/WD3 only move on a real write so they hold their last value otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      pend     <= '0;
      rf_we_o  <= 1'b0;
      rf_a3_o  <= '0;
      rf_wd3_o <= '0;
    end else begin
      state   <= state_nxt;
      rf_we_o <= (commit_new | commit_ld) & wr_en & (wr_rd != '0);
      if (xfer) begin
        pend.regwrite <= mem_regwrite_i;
        pend.rd       <= mem_rd_i;
      end
      if ((commit_new | commit_ld) && wr_en && wr_rd != '0) begin
        rf_a3_o  <= wr_rd;
        rf_wd3_o <= wr_dat;
      end
    end
  end

  wb_scoreboard u_sb (
    .clk            (clk),
    .rst            (rst),
    .iss_valid_i    (iss_valid_i),
    .iss_regwrite_i (iss_regwrite_i),
    .iss_rd_i       (iss_rd_i),
    .wr_en_i        (rf_we_o),
    .wr_rd_i        (rf_a3_o),
    .rs1_i          (rs1_i),
    .rs2_i          (rs2_i),
    .hazard_o       (hazard_o),
    .sb_ovf_o       (sb_ovf_o)
  );

endmodule

// File: tb/tb_wb_regfile_writer.sv
// Directed bench for wb_regfile_writer: writes, load wait, scoreboard hazards, overflow, x0, mid-reset.
module tb_wb_regfile_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i;
  logic        wb_ready_o;
  logic        mem_regwrite_i;
  logic [4:0]  mem_rd_i;
  logic [1:0]  mem_ressrc_i;
  logic [31:0] mem_alu_i;
  logic [31:0] mem_pc4_i;
  logic        ld_valid_i;
  logic [31:0] ld_data_i;
  logic        iss_valid_i;
  logic        iss_regwrite_i;
  logic [4:0]  iss_rd_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic        hazard_o;
  logic        rf_we_o;
  logic [4:0]  rf_a3_o;
  logic [31:0] rf_wd3_o;
  logic        sb_ovf_o;

  int vectors = 0;
  int errors  = 0;

  wb_regfile_writer dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid_i    (mem_valid_i),
    .wb_ready_o     (wb_ready_o),
    .mem_regwrite_i (mem_regwrite_i),
    .mem_rd_i       (mem_rd_i),
    .mem_ressrc_i   (mem_ressrc_i),
    .mem_alu_i      (mem_alu_i),
    .mem_pc4_i      (mem_pc4_i),
    .ld_valid_i     (ld_valid_i),
    .ld_data_i      (ld_data_i),
    .iss_valid_i    (iss_valid_i),
    .iss_regwrite_i (iss_regwrite_i),
    .iss_rd_i       (iss_rd_i),
    .rs1_i          (rs1_i),
    .rs2_i          (rs2_i),
    .hazard_o       (hazard_o),
    .rf_we_o        (rf_we_o),
    .rf_a3_o        (rf_a3_o),
    .rf_wd3_o       (rf_wd3_o),
    .sb_ovf_o       (sb_ovf_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mem_op(input logic rw, input logic [4:0] rd, input logic [1:0] src,
                        input logic [31:0] alu, input logic [31:0] pc4);
    mem_valid_i    = 1'b1;
    mem_regwrite_i = rw;
    mem_rd_i       = rd;
    mem_ressrc_i   = src;
    mem_alu_i      = alu;
    mem_pc4_i      = pc4;
  endtask

  initial begin
    rst = 1'b1;
    mem_valid_i = 1'b0; mem_regwrite_i = 1'b0; mem_rd_i = '0; mem_ressrc_i = '0;
    mem_alu_i = '0; mem_pc4_i = '0; ld_valid_i = 1'b0; ld_data_i = '0;
    iss_valid_i = 1'b0; iss_regwrite_i = 1'b0; iss_rd_i = '0; rs1_i = '0; rs2_i = '0;

    // Reset state
    tick(); tick();
    chk("rst_we", 32'(rf_we_o), 32'd0);
    chk("rst_a3", 32'(rf_a3_o), 32'd0);
    chk("rst_wd3", rf_wd3_o, 32'd0);
    chk("rst_ready", 32'(wb_ready_o), 32'd1);
    chk("rst_hazard", 32'(hazard_o), 32'd0);
    chk("rst_ovf", 32'(sb_ovf_o), 32'd0);
    rst = 1'b0;
    tick();

    // ALU write to x5: one cycle later, exactly one cycle long
    mem_op(1'b1, 5'd5, 2'b00, 32'hDEAD_BEEF, 32'h0000_0104);
    tick();
    mem_valid_i = 1'b0;
    chk("alu_we", 32'(rf_we_o), 32'd1);
    chk("alu_a3", 32'(rf_a3_o), 32'd5);
    chk("alu_wd3", rf_wd3_o, 32'hDEAD_BEEF);
    tick();
    chk("alu_we_drop", 32'(rf_we_o), 32'd0);
    chk("alu_a3_hold", 32'(rf_a3_o), 32'd5);
    chk("alu_wd3_hold", rf_wd3_o, 32'hDEAD_BEEF);

    // Back-to-back: PC+4 to x1, then reserved source (ALU) to x2
    mem_op(1'b1, 5'd1, 2'b10, 32'h0000_0055, 32'h0000_0104);
    tick();
    chk("pc4_we", 32'(rf_we_o), 32'd1);
    chk("pc4_a3", 32'(rf_a3_o), 32'd1);
    chk("pc4_wd3", rf_wd3_o, 32'h0000_0104);
    mem_op(1'b1, 5'd2, 2'b11, 32'h0000_A5A5, 32'h0000_0200);
    tick();
    mem_valid_i = 1'b0;
    chk("rsv_we", 32'(rf_we_o), 32'd1);
    chk("rsv_a3", 32'(rf_a3_o), 32'd2);
    chk("rsv_wd3", rf_wd3_o, 32'h0000_A5A5);
    tick();
    chk("b2b_idle_we", 32'(rf_we_o), 32'd0);

    // Late load to x7: ready low for three cycles, then one write of 0x1234
    mem_op(1'b1, 5'd7, 2'b01, 32'h0000_0BAD, 32'h0000_0300);
    tick();
    mem_valid_i = 1'b0;
    chk("ld_wait1_ready", 32'(wb_ready_o), 32'd0);
    chk("ld_wait1_we", 32'(rf_we_o), 32'd0);
    tick();
    chk("ld_wait2_ready", 32'(wb_ready_o), 32'd0);
    tick();
    chk("ld_wait3_ready", 32'(wb_ready_o), 32'd0);
    ld_valid_i = 1'b1; ld_data_i = 32'h0000_1234;
    tick();
    ld_valid_i = 1'b0; ld_data_i = 32'h0;
    chk("ld_we", 32'(rf_we_o), 32'd1);
    chk("ld_a3", 32'(rf_a3_o), 32'd7);
    chk("ld_wd3", rf_wd3_o, 32'h0000_1234);
    chk("ld_ready_back", 32'(wb_ready_o), 32'd1);
    tick();
    chk("ld_we_drop", 32'(rf_we_o), 32'd0);

    // Load with data in the transfer cycle writes immediately
    mem_op(1'b1, 5'd8, 2'b01, 32'h0, 32'h0);
    ld_valid_i = 1'b1; ld_data_i = 32'hCAFE_F00D;
    tick();
    mem_valid_i = 1'b0; ld_valid_i = 1'b0;
    chk("ldq_we", 32'(rf_we_o), 32'd1);
    chk("ldq_a3", 32'(rf_a3_o), 32'd8);
    chk("ldq_wd3", rf_wd3_o, 32'hCAFE_F00D);
    tick();

    // Hazard on x3: issuing instruction does not see itself; write cycle clears it
    iss_valid_i = 1'b1; iss_regwrite_i = 1'b1; iss_rd_i = 5'd3; rs1_i = 5'd3;
    #1;
    chk("haz_self_issue", 32'(hazard_o), 32'd0);
    tick();
    iss_valid_i = 1'b0;
    #1;
    chk("haz_x3_pending", 32'(hazard_o), 32'd1);
    mem_op(1'b1, 5'd3, 2'b00, 32'h0000_0033, 32'h0);
    tick();
    mem_valid_i = 1'b0;
    chk("haz_x3_write_we", 32'(rf_we_o), 32'd1);
    chk("haz_x3_write_cycle", 32'(hazard_o), 32'd0);
    tick();
    chk("haz_x3_after", 32'(hazard_o), 32'd0);

    // rs2 path: x4 pending, x5 clean
    iss_valid_i = 1'b1; iss_rd_i = 5'd4;
    tick();
    iss_valid_i = 1'b0; rs1_i = 5'd0; rs2_i = 5'd4;
    #1;
    chk("haz_rs2_x4", 32'(hazard_o), 32'd1);
    rs2_i = 5'd5;
    #1;
    chk("haz_rs2_x5", 32'(hazard_o), 32'd0);
    rs2_i = 5'd0;

    // Saturation on x9: three issues fit, the fourth overflows
    iss_valid_i = 1'b1; iss_rd_i = 5'd9;
    tick(); tick(); tick();
    chk("ovf_at_three", 32'(sb_ovf_o), 32'd0);
    tick();
    iss_valid_i = 1'b0; rs1_i = 5'd9;
    chk("ovf_fourth", 32'(sb_ovf_o), 32'd1);
    #1;
    chk("ovf_haz", 32'(hazard_o), 32'd1);
    mem_op(1'b1, 5'd9, 2'b00, 32'h0000_0009, 32'h0);
    tick();
    chk("drain1_haz", 32'(hazard_o), 32'd1);
    tick();
    chk("drain2_haz", 32'(hazard_o), 32'd1);
    tick();
    mem_valid_i = 1'b0;
    chk("drain3_we", 32'(rf_we_o), 32'd1);
    chk("drain3_haz", 32'(hazard_o), 32'd0);
    tick();
    chk("drained_haz", 32'(hazard_o), 32'd0);
    chk("ovf_sticky", 32'(sb_ovf_o), 32'd1);

    // x0: never written, never a hazard
    mem_op(1'b1, 5'd0, 2'b00, 32'h0000_0077, 32'h0);
    tick();
    mem_valid_i = 1'b0;
    chk("x0_we", 32'(rf_we_o), 32'd0);
    chk("x0_a3_hold", 32'(rf_a3_o), 32'd9);
    iss_valid_i = 1'b1; iss_rd_i = 5'd0; rs1_i = 5'd0;
    tick();
    iss_valid_i = 1'b0;
    #1;
    chk("x0_haz", 32'(hazard_o), 32'd0);

    // Reset while waiting for load data to x6 (with x4 and x6 pending)
    iss_valid_i = 1'b1; iss_rd_i = 5'd6;
    tick();
    iss_valid_i = 1'b0;
    mem_op(1'b1, 5'd6, 2'b01, 32'h0, 32'h0);
    tick();
    mem_valid_i = 1'b0;
    chk("mrst_wait_ready", 32'(wb_ready_o), 32'd0);
    rst = 1'b1; ld_valid_i = 1'b1; ld_data_i = 32'hFFFF_FFFF;
    tick();
    rst = 1'b0; ld_valid_i = 1'b0; ld_data_i = 32'h0;
    rs1_i = 5'd6; rs2_i = 5'd4;
    #1;
    chk("mrst_ready", 32'(wb_ready_o), 32'd1);
    chk("mrst_we", 32'(rf_we_o), 32'd0);
    chk("mrst_a3", 32'(rf_a3_o), 32'd0);
    chk("mrst_ovf", 32'(sb_ovf_o), 32'd0);
    chk("mrst_haz", 32'(hazard_o), 32'd0);
    tick();
    chk("mrst_no_write", 32'(rf_we_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
